// File: rtl/ras_ckpt.sv
// ras_ckpt: circular return-address stack with an in-order checkpoint FIFO.
// Calls push, returns pop. Each predicted branch snapshots {tos, count} into
// the FIFO. In-order resolution either retires the oldest snapshot or rolls
// the stack back to it. A push onto a full stack overwrites the oldest entry.
//
// Optional feature: define RAS_CKPT_TOS_REPAIR_EN to also snapshot the top
// value and write it back into mem[restored tos] on a rollback. This repairs
// a top entry clobbered by a speculative pop-then-push.
module ras_ckpt #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int ADDR      = $clog2(DEPTH),
    parameter int NCKPT     = 4,
    parameter int CKPT_ADDR = $clog2(NCKPT)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [WIDTH-1:0]     din_i,
    output logic [WIDTH-1:0]     dout_o,
    output logic                 empty_o,
    output logic                 full_o,
    input  logic                 branch_i,
    input  logic                 close_valid_i,
    input  logic                 close_invalid_i,
    output logic [CKPT_ADDR:0]   ckpt_count_o,
    output logic                 ckpt_full_o,
    output logic                 ckpt_drop_o
);

    localparam logic [ADDR:0]      DEPTH_C = (ADDR+1)'(DEPTH);
    localparam logic [CKPT_ADDR:0] NCKPT_C = (CKPT_ADDR+1)'(NCKPT);

    // stack storage and pointers
    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [ADDR-1:0]      tos_q, tos_d;
    logic [ADDR:0]        cnt_q, cnt_d;

    // checkpoint FIFO payload and pointers
    logic [ADDR-1:0]      ck_tos_q [NCKPT];
    logic [ADDR:0]        ck_cnt_q [NCKPT];
`ifdef RAS_CKPT_TOS_REPAIR_EN
    logic [WIDTH-1:0]     ck_top_q [NCKPT];
`endif
    logic [CKPT_ADDR-1:0] head_q, head_d, tail_q, tail_d;
    logic [CKPT_ADDR:0]   ccnt_q, ccnt_d;

    logic                 stack_empty, ck_empty, ck_full;
    logic                 restore, deq, enq, do_pop;
    logic                 mem_we;
    logic [ADDR-1:0]      mem_waddr;
    logic [WIDTH-1:0]     mem_wdata;

    // request decode; a rollback swallows every other same-cycle request
    always_comb begin
        stack_empty = (cnt_q == '0);
        ck_empty    = (ccnt_q == '0);
        ck_full     = (ccnt_q == NCKPT_C);
        restore     = close_invalid_i && !ck_empty;
        deq         = !restore && close_valid_i && !ck_empty;
        enq         = !restore && branch_i && (!ck_full || deq);
        do_pop      = pop_i && !stack_empty;
    end

    // stack next state and the single memory write port
    always_comb begin
        tos_d     = tos_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = tos_q;
        mem_wdata = din_i;
        if (restore) begin
            tos_d = ck_tos_q[head_q];
            cnt_d = ck_cnt_q[head_q];
`ifdef RAS_CKPT_TOS_REPAIR_EN
            mem_we    = 1'b1;
            mem_waddr = ck_tos_q[head_q];
            mem_wdata = ck_top_q[head_q];
`endif
        end else if (push_i && do_pop) begin
            // return immediately followed by a call: replace the top in place
            mem_we = 1'b1;
        end else if (push_i) begin
            tos_d     = tos_q + 1'b1;
            mem_we    = 1'b1;
            mem_waddr = tos_q + 1'b1;
            // when full the oldest entry is overwritten, count saturates
            if (cnt_q != DEPTH_C) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (do_pop) begin
            tos_d = tos_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    // checkpoint FIFO pointer next state
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        ccnt_d = ccnt_q;
        if (restore) begin
            head_d = '0;
            tail_d = '0;
            ccnt_d = '0;
        end else begin
            if (deq) begin
                head_d = head_q + 1'b1;
            end
            if (enq) begin
                tail_d = tail_q + 1'b1;
            end
            case ({enq, deq})
                2'b10:   ccnt_d = ccnt_q + 1'b1;
                2'b01:   ccnt_d = ccnt_q - 1'b1;
                default: ccnt_d = ccnt_q;
            endcase
        end
    end

    // pointer and count registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tos_q  <= ADDR'(DEPTH - 1);
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            ccnt_q <= '0;
        end else begin
            tos_q  <= tos_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            ccnt_q <= ccnt_d;
        end
    end

    // stack memory, deliberately not reset
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // checkpoint payload captures the state seen before this cycle's push/pop
    always_ff @(posedge clk_i) begin
        if (enq) begin
            ck_tos_q[tail_q] <= tos_q;
            ck_cnt_q[tail_q] <= cnt_q;
`ifdef RAS_CKPT_TOS_REPAIR_EN
            ck_top_q[tail_q] <= dout_o;
`endif
        end
    end

    // outputs
    always_comb begin
        dout_o       = stack_empty ? '0 : mem_q[tos_q];
        empty_o      = stack_empty;
        full_o       = (cnt_q == DEPTH_C);
        ckpt_count_o = ccnt_q;
        ckpt_full_o  = ck_full;
        ckpt_drop_o  = branch_i && !restore && !enq;
    end

endmodule

// File: tb/tb_ras_ckpt.sv
// Bench for ras_ckpt: directed scenarios followed by randomized traffic,
// all checked against a queue/array reference model.
module tb_ras_ckpt;

    localparam int DEPTH = 16;
    localparam int NCKPT = 4;

    logic        clk, rst;
    logic        push, pop, branch, close_valid, close_invalid;
    logic [31:0] din, dout;
    logic        empty, full, ckpt_full, ckpt_drop;
    logic [2:0]  ckpt_count;

    int n_run  = 0;
    int n_fail = 0;

    ras_ckpt dut (
        .clk_i(clk), .rst_i(rst), .push_i(push), .pop_i(pop), .din_i(din),
        .dout_o(dout), .empty_o(empty), .full_o(full), .branch_i(branch),
        .close_valid_i(close_valid), .close_invalid_i(close_invalid),
        .ckpt_count_o(ckpt_count), .ckpt_full_o(ckpt_full), .ckpt_drop_o(ckpt_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model
    typedef struct {
        int          tos;
        int          cnt;
        logic [31:0] top;
    } ck_t;

    logic [31:0] m_mem [DEPTH];
    int          m_tos, m_cnt;
    ck_t         m_ck [$];

    function automatic logic [31:0] m_dout();
        return (m_cnt == 0) ? 32'd0 : m_mem[m_tos];
    endfunction

    task automatic m_reset();
        m_tos = DEPTH - 1;
        m_cnt = 0;
        m_ck.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("dout",       dout,              m_dout());
        chk("empty",      {31'd0, empty},    {31'd0, m_cnt == 0});
        chk("full",       {31'd0, full},     {31'd0, m_cnt == DEPTH});
        chk("ckpt_count", {29'd0, ckpt_count}, 32'(m_ck.size()));
        chk("ckpt_full",  {31'd0, ckpt_full},  {31'd0, m_ck.size() == NCKPT});
    endtask

    // one clock of stimulus; entered and left 1 time unit after a rising edge
    task automatic cyc(input logic p, input logic po, input logic [31:0] d,
                       input logic br, input logic cv, input logic ci);
        bit  restore, deq, enq;
        ck_t snap;
        push = p; pop = po; din = d; branch = br; close_valid = cv; close_invalid = ci;
        #1;
        restore = ci && (m_ck.size() > 0);
        chk("ckpt_drop", {31'd0, ckpt_drop},
            {31'd0, br && !restore && (m_ck.size() == NCKPT) && !cv});
        @(posedge clk);
        snap.tos = m_tos;
        snap.cnt = m_cnt;
        snap.top = m_dout();
        if (restore) begin
            m_tos = m_ck[0].tos;
            m_cnt = m_ck[0].cnt;
`ifdef RAS_CKPT_TOS_REPAIR_EN
            m_mem[m_tos] = m_ck[0].top;
`endif
            m_ck.delete();
        end else begin
            deq = cv && (m_ck.size() > 0);
            enq = br && ((m_ck.size() < NCKPT) || deq);
            if (deq) void'(m_ck.pop_front());
            if (enq) m_ck.push_back(snap);
            if (p && po && m_cnt > 0) begin
                m_mem[m_tos] = d;
            end else if (p) begin
                m_tos = (m_tos + 1) % DEPTH;
                m_mem[m_tos] = d;
                if (m_cnt < DEPTH) m_cnt++;
            end else if (po && m_cnt > 0) begin
                m_tos = (m_tos + DEPTH - 1) % DEPTH;
                m_cnt--;
            end
        end
        #1;
        chk_outputs();
    endtask

    task automatic do_push(input logic [31:0] d); cyc(1, 0, d, 0, 0, 0); endtask
    task automatic do_pop();                      cyc(0, 1, 0, 0, 0, 0); endtask

    // async reset asserted between edges, with whatever inputs are being driven
    task automatic do_reset();
        #1;
        rst = 1'b1;
        #1;
        m_reset();
        chk("rst_empty",      {31'd0, empty},      32'd1);
        chk("rst_ckpt_count", {29'd0, ckpt_count}, 32'd0);
        chk("rst_dout",       dout,                32'd0);
        chk("rst_full",       {31'd0, full},       32'd0);
        push = 0; pop = 0; din = 0; branch = 0; close_valid = 0; close_invalid = 0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_outputs();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        rst = 1'b1;
        push = 0; pop = 0; din = 0; branch = 0; close_valid = 0; close_invalid = 0;
        m_reset();
        #2;
        chk_outputs();
        chk("reset_drop", {31'd0, ckpt_drop}, 32'd0);
        #5;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // basic push/pop and pop on empty
        do_push(32'h100);
        do_push(32'h200);
        chk("tp1_top", dout, 32'h200);
        do_pop();
        chk("tp1_pop1", dout, 32'h100);
        do_pop();
        chk("tp1_pop2_empty", {31'd0, empty}, 32'd1);
        do_pop();
        do_push(32'h7);
        do_pop();
        chk("tp1_count0", {31'd0, empty}, 32'd1);

        // overflow wraps and drops the oldest entry
        do_reset();
        for (int i = 1; i <= 17; i++) do_push(32'(i));
        chk("tp2_full", {31'd0, full}, 32'd1);
        for (int i = 17; i >= 2; i--) begin
            chk("tp2_seq", dout, 32'(i));
            do_pop();
        end
        chk("tp2_empty", {31'd0, empty}, 32'd1);

        // rollback after speculative pop then push
        do_reset();
        do_push(32'hA);
        do_push(32'hB);
        cyc(0, 0, 0, 1, 0, 0);
        do_pop();
        do_push(32'hC);
        cyc(0, 0, 0, 0, 0, 1);
`ifdef RAS_CKPT_TOS_REPAIR_EN
        chk("tp3_restore", dout, 32'hB);
`else
        chk("tp3_restore", dout, 32'hC);
`endif
        do_pop();
        chk("tp3_below", dout, 32'hA);

        // checkpoint FIFO full, drop, and simultaneous retire + take
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0);
        chk("tp4_ckfull", {31'd0, ckpt_full}, 32'd1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("tp4_cnt_after_drop", {29'd0, ckpt_count}, 32'd4);
        cyc(0, 0, 0, 1, 1, 0);
        chk("tp4_cnt_swap", {29'd0, ckpt_count}, 32'd4);

        // retire one, roll back to the next
        do_reset();
        do_push(32'h1);
        cyc(0, 0, 0, 1, 0, 0);
        do_push(32'h2);
        cyc(0, 0, 0, 1, 0, 0);
        do_push(32'h3);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("tp5_dout", dout, 32'h2);
        chk("tp5_ckcnt", {29'd0, ckpt_count}, 32'd0);
        do_pop();
        chk("tp5_below", dout, 32'h1);

        // push+pop replaces the top; reset during speculation
        do_reset();
        do_push(32'h5);
        cyc(1, 1, 32'h9, 0, 0, 0);
        chk("tp6_replace", dout, 32'h9);
        do_pop();
        chk("tp6_cnt", {31'd0, empty}, 32'd1);
        do_push(32'h4);
        cyc(1, 0, 32'h6, 1, 0, 0);
        push = 1; branch = 1; din = 32'h8;
        do_reset();

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 40, $urandom(),
                    $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 25,
                    $urandom_range(0, 99) < 5);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
